copperv_mem_bridge: RTL and testbench
=====================================

Name: copperv_mem_bridge

Overview:
Slave-side bus bridge directly downstream of the copperv core. It accepts the core's three channels: instruction read (ir), data read (dr) and data write (dw). It arbitrates them onto one single-port, word-addressed memory interface with a req/gnt plus rvalid protocol. It returns read data and write responses over the core's valid/ready handshakes. The core pulses each request valid for exactly one cycle, so the bridge registers every request in a per-channel holding slot.

Parameters:
BUS_WIDTH, 32, data/address width of all core channels
BUS_RESP_WIDTH, 1, width of dw_resp
MEM_AW, 14, memory word-address width; valid byte range is 0 .. 4*2^MEM_AW-1
RESP_OK, 1, dw_resp code for a completed write
RESP_FAIL, 0, dw_resp code for a rejected write

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
ir_addr_valid  in  1  instruction fetch request pulse
ir_addr  in  BUS_WIDTH  fetch byte address
ir_addr_ready  out  1  ir slot free
ir_data_valid  out  1  fetch data valid
ir_data  out  BUS_WIDTH  fetched word
ir_data_ready  in  1  core accepts fetch data
dr_addr_valid / dr_addr / dr_addr_ready  in / in BUS_WIDTH / out  load request; same rules as ir
dr_data_valid / dr_data / dr_data_ready  out / out BUS_WIDTH / in  load data
dw_data_addr_valid  in  1  store request pulse
dw_addr  in  BUS_WIDTH  store byte address
dw_data  in  BUS_WIDTH  store data
dw_strobe  in  BUS_WIDTH/8  byte enables
dw_data_addr_ready  out  1  dw slot free
dw_resp_valid  out  1  write response valid
dw_resp  out  BUS_RESP_WIDTH  RESP_OK or RESP_FAIL
dw_resp_ready  in  1  core accepts response
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  1 = write
mem_addr  out  MEM_AW  word address = byte address[MEM_AW+1:2]
mem_wdata  out  BUS_WIDTH  write data
mem_wstrobe  out  BUS_WIDTH/8  byte enables
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid; at least 1 cycle after the read gnt
mem_rdata  in  BUS_WIDTH  read data

Behaviour:
- Reset (rst low, asynchronous) clears all slots, response registers and FSM state. mem_req drops immediately.
- Output reset values: all *_addr_ready = 1. All data_valid, dw_resp_valid, mem_req and mem_we = 0. dw_resp = RESP_FAIL. Data and address outputs = 0.
- Slots: per channel, *_addr_ready = !slot_pending && !resp_valid, derived combinationally from registers. valid && ready captures address/data/strobe and sets slot_pending. A valid seen while ready=0 is a protocol error and is ignored.
- Outstanding limit: one per channel. The slot frees only after the channel's response handshake (resp_valid && ready).
- FSM states:
  - IDLE: pick a pending slot. Channel order is dw over dr. Between ir and data, when both are pending, choose the class not served last; last_ir resets to 0. In-range requests go to REQ; out-of-range requests go to DONE.
  - REQ: mem_req=1 with stable mem_* fields. On mem_gnt, a write goes to DONE and a read goes to RWAIT.
  - RWAIT: on mem_rvalid, capture mem_rdata and go to DONE.
  - DONE: set the channel's response register, clear slot_pending, go to IDLE.
- Out-of-range: any address bits above MEM_AW+1 set. No memory access is made. A write returns RESP_FAIL. A read returns data 0.
- Responses: *_data_valid / dw_resp_valid is held with stable data until ready. Ready=1 at the same edge the response is set means it is consumed on the next cycle. A response waiting on a stalled consumer does not block the FSM serving other channels.
- Latency, capture edge E0, mem_gnt asserted in the first REQ cycle:
  - mem_req is high in the cycle after E1.
  - Write: dw_resp_valid is high after E3.
  - Read with rvalid one cycle after gnt: data_valid is high after E4.
  - Out-of-range: response is high after E2.
- Simultaneous events: a slot may be captured in the same cycle another channel is in REQ/RWAIT. A capture and a response set on the same channel cannot coincide, because ready=0 while pending.
- mem_wstrobe = 0 and mem_we = 0 for reads.

Test Plan:
- Single fetch: ir_addr=0x100 pulse, mem_gnt immediate, rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x40, mem_we=0, ir_data=0xDEADBEEF, ir_data_valid after E4, ir_addr_ready back to 1 after the handshake.
- Store: dw_addr=0x8, dw_data=0x12345678, strobe=0b0011 -> mem_we=1, mem_addr=0x2, mem_wstrobe=0b0011, dw_resp=RESP_OK after E3.
- Contention: ir, dr and dw all pulse in the same cycle, last_ir=0 -> service order ir, dw, ir-class free so dr next. Each is one mem_req, none is lost.
- Out-of-range: dw_addr=0x0004_0000 with MEM_AW=14 -> no mem_req, dw_resp=RESP_FAIL. dr_addr=0xFFFF_FFFC -> no mem_req, dr_data=0.
- Backpressure: dr_data_ready=0 for 10 cycles after data is ready -> dr_data_valid and dr_data stay stable, dr_addr_ready=0, and an ir fetch issued meanwhile still completes.
- Reset mid-read: assert rst low in RWAIT -> mem_req=0 and all valids 0 immediately, all *_addr_ready=1. A late mem_rvalid after release is ignored.

Source files
------------

// File: rtl/copperv_mem_bridge.sv
// copperv_mem_bridge: arbitrates the copperv ir/dr/dw channels onto one
// single-port, word-addressed memory with req/gnt and rvalid.
`timescale 1ns/1ps
module copperv_mem_bridge #(
    parameter int BUS_WIDTH = 32,
    parameter int BUS_RESP_WIDTH = 1,
    parameter int MEM_AW = 14,
    parameter logic [BUS_RESP_WIDTH-1:0] RESP_OK = BUS_RESP_WIDTH'(1),
    parameter logic [BUS_RESP_WIDTH-1:0] RESP_FAIL = BUS_RESP_WIDTH'(0)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ir_addr_valid,
    input  logic [BUS_WIDTH-1:0]      ir_addr,
    output logic                      ir_addr_ready,
    output logic                      ir_data_valid,
    output logic [BUS_WIDTH-1:0]      ir_data,
    input  logic                      ir_data_ready,
    input  logic                      dr_addr_valid,
    input  logic [BUS_WIDTH-1:0]      dr_addr,
    output logic                      dr_addr_ready,
    output logic                      dr_data_valid,
    output logic [BUS_WIDTH-1:0]      dr_data,
    input  logic                      dr_data_ready,
    input  logic                      dw_data_addr_valid,
    input  logic [BUS_WIDTH-1:0]      dw_addr,
    input  logic [BUS_WIDTH-1:0]      dw_data,
    input  logic [BUS_WIDTH/8-1:0]    dw_strobe,
    output logic                      dw_data_addr_ready,
    output logic                      dw_resp_valid,
    output logic [BUS_RESP_WIDTH-1:0] dw_resp,
    input  logic                      dw_resp_ready,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_AW-1:0]         mem_addr,
    output logic [BUS_WIDTH-1:0]      mem_wdata,
    output logic [BUS_WIDTH/8-1:0]    mem_wstrobe,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [BUS_WIDTH-1:0]      mem_rdata
);

    localparam int SW = BUS_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;
    typedef enum logic [1:0] {CH_IR, CH_DR, CH_DW} chan_t;

    state_t state, state_nx;
    chan_t  ch, pick_ch;

    logic                 ir_pend, dr_pend, dw_pend;
    logic                 last_ir, oor_q;
    logic [BUS_WIDTH-1:0] ir_a, dr_a, dw_a, dw_d;
    logic [SW-1:0]        dw_s;
    logic [BUS_WIDTH-1:0] rdata_q, pick_addr;
    logic                 take_ir, take_dw, any_pend, pick_oor, start;
    logic                 unused_bits;

    assign ir_addr_ready      = !ir_pend && !ir_data_valid;
    assign dr_addr_ready      = !dr_pend && !dr_data_valid;
    assign dw_data_addr_ready = !dw_pend && !dw_resp_valid;
    assign mem_req            = (state == REQ);

    // ir competes with the data class as a whole; dw beats dr inside it
    assign take_ir  = ir_pend && (!(dr_pend || dw_pend) || !last_ir);
    assign take_dw  = !take_ir && dw_pend;
    assign any_pend = ir_pend || dr_pend || dw_pend;

    always_comb begin
        pick_ch   = CH_DR;
        pick_addr = dr_a;
        unique case (1'b1)
            take_ir: begin
                pick_ch   = CH_IR;
                pick_addr = ir_a;
            end
            take_dw: begin
                pick_ch   = CH_DW;
                pick_addr = dw_a;
            end
            default: ;
        endcase
    end

    assign pick_oor    = |pick_addr[BUS_WIDTH-1:MEM_AW+2];
    assign unused_bits = ^pick_addr[1:0];

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_pend) begin
                    start    = 1'b1;
                    state_nx = pick_oor ? DONE : REQ;
                end
            end
            REQ:     if (mem_gnt) state_nx = mem_we ? DONE : RWAIT;
            RWAIT:   if (mem_rvalid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_pend       <= 1'b0;
            dr_pend       <= 1'b0;
            dw_pend       <= 1'b0;
            ir_a          <= '0;
            dr_a          <= '0;
            dw_a          <= '0;
            dw_d          <= '0;
            dw_s          <= '0;
            ch            <= CH_IR;
            last_ir       <= 1'b0;
            oor_q         <= 1'b0;
            rdata_q       <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrobe   <= '0;
            ir_data_valid <= 1'b0;
            ir_data       <= '0;
            dr_data_valid <= 1'b0;
            dr_data       <= '0;
            dw_resp_valid <= 1'b0;
            dw_resp       <= RESP_FAIL;
        end else begin
            if (ir_addr_valid && ir_addr_ready) begin
                ir_pend <= 1'b1;
                ir_a    <= ir_addr;
            end
            if (dr_addr_valid && dr_addr_ready) begin
                dr_pend <= 1'b1;
                dr_a    <= dr_addr;
            end
            if (dw_data_addr_valid && dw_data_addr_ready) begin
                dw_pend <= 1'b1;
                dw_a    <= dw_addr;
                dw_d    <= dw_data;
                dw_s    <= dw_strobe;
            end
            if (ir_data_valid && ir_data_ready) ir_data_valid <= 1'b0;
            if (dr_data_valid && dr_data_ready) dr_data_valid <= 1'b0;
            if (dw_resp_valid && dw_resp_ready) dw_resp_valid <= 1'b0;
            if (start) begin
                ch      <= pick_ch;
                last_ir <= (pick_ch == CH_IR);
                oor_q   <= pick_oor;
                rdata_q <= '0;
                // rejected requests never touch the memory fields
                if (!pick_oor) begin
                    mem_addr    <= pick_addr[MEM_AW+1:2];
                    mem_we      <= (pick_ch == CH_DW);
                    mem_wdata   <= (pick_ch == CH_DW) ? dw_d : '0;
                    mem_wstrobe <= (pick_ch == CH_DW) ? dw_s : '0;
                end
            end
            if (state == RWAIT && mem_rvalid) rdata_q <= mem_rdata;
            if (state == DONE) begin
                unique case (ch)
                    CH_IR: begin
                        ir_pend       <= 1'b0;
                        ir_data_valid <= 1'b1;
                        ir_data       <= rdata_q;
                    end
                    CH_DR: begin
                        dr_pend       <= 1'b0;
                        dr_data_valid <= 1'b1;
                        dr_data       <= rdata_q;
                    end
                    default: begin
                        dw_pend       <= 1'b0;
                        dw_resp_valid <= 1'b1;
                        dw_resp       <= oor_q ? RESP_FAIL : RESP_OK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_copperv_mem_bridge.sv
// Directed bench for copperv_mem_bridge with a small req/gnt/rvalid
// memory responder and per-channel response monitors.
`timescale 1ns/1ps
module tb_copperv_mem_bridge;

    localparam int BW = 32;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
    logic [BW-1:0] ir_addr, ir_data;
    logic          dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
    logic [BW-1:0] dr_addr, dr_data;
    logic          dw_data_addr_valid, dw_data_addr_ready;
    logic [BW-1:0] dw_addr, dw_data;
    logic [3:0]    dw_strobe;
    logic          dw_resp_valid, dw_resp_ready;
    logic [0:0]    dw_resp;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wstrobe;

    always #5 clk = ~clk;

    copperv_mem_bridge dut (
        .clk(clk), .rst(rst),
        .ir_addr_valid(ir_addr_valid), .ir_addr(ir_addr),
        .ir_addr_ready(ir_addr_ready), .ir_data_valid(ir_data_valid),
        .ir_data(ir_data), .ir_data_ready(ir_data_ready),
        .dr_addr_valid(dr_addr_valid), .dr_addr(dr_addr),
        .dr_addr_ready(dr_addr_ready), .dr_data_valid(dr_data_valid),
        .dr_data(dr_data), .dr_data_ready(dr_data_ready),
        .dw_data_addr_valid(dw_data_addr_valid), .dw_addr(dw_addr),
        .dw_data(dw_data), .dw_strobe(dw_strobe),
        .dw_data_addr_ready(dw_data_addr_ready),
        .dw_resp_valid(dw_resp_valid), .dw_resp(dw_resp),
        .dw_resp_ready(dw_resp_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrobe(mem_wstrobe),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // memory responder: gnt follows req, rvalid rd_lat cycles after gnt
    logic          gnt_en = 1'b1;
    int            rd_lat = 1;
    int            rd_cnt = 0;
    int            n_req = 0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] req_log[$];

    assign mem_gnt    = mem_req && gnt_en;
    assign mem_rvalid = (rd_cnt == 1);
    assign mem_rdata  = (rd_addr == 14'h40) ? 32'hDEADBEEF
                                            : {16'hC0DE, 2'b00, rd_addr};

    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            n_req <= n_req + 1;
            req_log.push_back(mem_addr);
        end
        if (mem_req && mem_gnt && !mem_we) begin
            rd_cnt  <= rd_lat;
            rd_addr <= mem_addr;
        end else if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 1;
        end
    end

    int          ir_cnt = 0, dr_cnt = 0, dw_cnt = 0;
    logic [31:0] ir_last = '0, dr_last = '0;
    logic [0:0]  dw_last = '0;

    always @(posedge clk) begin
        if (ir_data_valid && ir_data_ready) begin
            ir_cnt  <= ir_cnt + 1;
            ir_last <= ir_data;
        end
        if (dr_data_valid && dr_data_ready) begin
            dr_cnt  <= dr_cnt + 1;
            dr_last <= dr_data;
        end
        if (dw_resp_valid && dw_resp_ready) begin
            dw_cnt  <= dw_cnt + 1;
            dw_last <= dw_resp;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ir(input logic [31:0] a);
        @(negedge clk);
        ir_addr = a;
        ir_addr_valid = 1'b1;
        @(posedge clk);
        #1;
        ir_addr_valid = 1'b0;
    endtask

    task automatic pulse_dr(input logic [31:0] a);
        @(negedge clk);
        dr_addr = a;
        dr_addr_valid = 1'b1;
        @(posedge clk);
        #1;
        dr_addr_valid = 1'b0;
    endtask

    task automatic pulse_dw(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        @(negedge clk);
        dw_addr = a;
        dw_data = d;
        dw_strobe = s;
        dw_data_addr_valid = 1'b1;
        @(posedge clk);
        #1;
        dw_data_addr_valid = 1'b0;
    endtask

    int   base, ir_b, dr_b, dw_b, req_b;
    logic bp_ok;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ir_addr_valid = 0; ir_addr = '0; ir_data_ready = 1;
        dr_addr_valid = 0; dr_addr = '0; dr_data_ready = 1;
        dw_data_addr_valid = 0; dw_addr = '0; dw_data = '0;
        dw_strobe = '0; dw_resp_ready = 1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ir_rdy", 32'(ir_addr_ready), 1);
        check("rst_dr_rdy", 32'(dr_addr_ready), 1);
        check("rst_dw_rdy", 32'(dw_data_addr_ready), 1);
        check("rst_valids", 32'({ir_data_valid, dr_data_valid, dw_resp_valid}), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_dw_resp", 32'(dw_resp), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        @(negedge clk) rst = 1'b1;
        step();

        // single fetch
        pulse_ir(32'h100);
        check("f_rdy_busy", 32'(ir_addr_ready), 0);
        step();
        check("f_req", 32'(mem_req), 1);
        check("f_addr", 32'(mem_addr), 32'h40);
        check("f_we", 32'(mem_we), 0);
        check("f_strb", 32'(mem_wstrobe), 0);
        step();
        check("f_req_drop", 32'(mem_req), 0);
        step();
        check("f_valid_e3", 32'(ir_data_valid), 0);
        step();
        check("f_valid_e4", 32'(ir_data_valid), 1);
        check("f_data", ir_data, 32'hDEADBEEF);
        step();
        check("f_rdy_back", 32'(ir_addr_ready), 1);

        // store
        pulse_dw(32'h8, 32'h12345678, 4'b0011);
        step();
        check("s_req", 32'(mem_req), 1);
        check("s_we", 32'(mem_we), 1);
        check("s_addr", 32'(mem_addr), 32'h2);
        check("s_strb", 32'(mem_wstrobe), 32'h3);
        check("s_wdata", mem_wdata, 32'h12345678);
        step();
        check("s_valid_e2", 32'(dw_resp_valid), 0);
        step();
        check("s_valid_e3", 32'(dw_resp_valid), 1);
        check("s_resp", 32'(dw_resp), 1);
        step();

        // contention: all three in one cycle
        base = req_log.size();
        ir_b = ir_cnt; dr_b = dr_cnt; dw_b = dw_cnt;
        @(negedge clk);
        ir_addr = 32'h200; dr_addr = 32'h300;
        dw_addr = 32'h400; dw_data = 32'hCAFE0001; dw_strobe = 4'hF;
        ir_addr_valid = 1; dr_addr_valid = 1; dw_data_addr_valid = 1;
        @(posedge clk);
        #1;
        ir_addr_valid = 0; dr_addr_valid = 0; dw_data_addr_valid = 0;
        for (int i = 0; i < 60 && (ir_cnt == ir_b || dr_cnt == dr_b
             || dw_cnt == dw_b); i++) step();
        check("c_ir_done", ir_cnt, ir_b + 1);
        check("c_dr_done", dr_cnt, dr_b + 1);
        check("c_dw_done", dw_cnt, dw_b + 1);
        check("c_nreq", req_log.size(), base + 3);
        if (req_log.size() >= base + 3) begin
            check("c_order0", 32'(req_log[base]), 32'h80);
            check("c_order1", 32'(req_log[base+1]), 32'h100);
            check("c_order2", 32'(req_log[base+2]), 32'hC0);
        end
        check("c_ir_data", ir_last, 32'hC0DE0080);
        check("c_dr_data", dr_last, 32'hC0DE00C0);
        check("c_dw_resp", 32'(dw_last), 1);
        step();

        // out-of-range
        req_b = n_req;
        pulse_dw(32'h0004_0000, 32'hAAAA5555, 4'hF);
        step();
        check("o_w_noreq", 32'(mem_req), 0);
        step();
        check("o_w_valid", 32'(dw_resp_valid), 1);
        check("o_w_resp", 32'(dw_resp), 0);
        step();
        pulse_dr(32'hFFFF_FFFC);
        step();
        step();
        check("o_r_valid", 32'(dr_data_valid), 1);
        check("o_r_data", dr_data, 0);
        step();
        check("o_nreq", n_req, req_b);

        // backpressure on dr while ir proceeds
        dr_data_ready = 0;
        dr_b = dr_cnt; ir_b = ir_cnt;
        pulse_dr(32'h500);
        for (int i = 0; i < 20 && !dr_data_valid; i++) step();
        check("b_valid", 32'(dr_data_valid), 1);
        check("b_data", dr_data, 32'hC0DE0140);
        bp_ok = 1'b1;
        pulse_ir(32'h600);
        for (int i = 0; i < 9; i++) begin
            step();
            if (!dr_data_valid || dr_data !== 32'hC0DE0140 || dr_addr_ready)
                bp_ok = 1'b0;
        end
        check("b_stable", 32'(bp_ok), 1);
        check("b_ir_done", ir_cnt, ir_b + 1);
        check("b_ir_data", ir_last, 32'hC0DE0180);
        dr_data_ready = 1;
        step();
        step();
        check("b_dr_done", dr_cnt, dr_b + 1);
        check("b_dr_rdy", 32'(dr_addr_ready), 1);

        // reset while a request waits for gnt
        gnt_en = 0;
        pulse_ir(32'h10);
        step();
        check("rq_req", 32'(mem_req), 1);
        #2 rst = 1'b0;
        #1;
        check("rq_req_drop", 32'(mem_req), 0);
        check("rq_ir_rdy", 32'(ir_addr_ready), 1);
        @(negedge clk) rst = 1'b1;
        gnt_en = 1;
        step();

        // reset in RWAIT with a stalled write response pending
        dw_resp_ready = 0;
        pulse_dw(32'h20, 32'h1, 4'h1);
        for (int i = 0; i < 20 && !dw_resp_valid; i++) step();
        check("rw_dw_held", 32'(dw_resp), 1);
        rd_lat = 5;
        pulse_dr(32'h700);
        step();
        step();
        #2 rst = 1'b0;
        #1;
        check("rw_req", 32'(mem_req), 0);
        check("rw_valids", 32'({ir_data_valid, dr_data_valid, dw_resp_valid}), 0);
        check("rw_rdys", 32'({ir_addr_ready, dr_addr_ready, dw_data_addr_ready}), 32'h7);
        check("rw_dw_resp", 32'(dw_resp), 0);
        check("rw_mem_addr", 32'(mem_addr), 0);
        dw_resp_ready = 1;
        dr_b = dr_cnt; req_b = n_req;
        @(negedge clk) rst = 1'b1;
        repeat (8) step();
        check("rw_late_valid", 32'(dr_data_valid), 0);
        check("rw_late_cnt", dr_cnt, dr_b);
        check("rw_late_nreq", n_req, req_b);
        rd_lat = 1;
        pulse_dr(32'h700);
        for (int i = 0; i < 20 && dr_cnt == dr_b; i++) step();
        check("rw_after", dr_last, 32'hC0DE01C0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
